// File: rtl/sram_access_arbiter.sv
// Two-port arbiter in front of a single-port synchronous SRAM.
// Port 0 is the serial loader and port 1 is the CPU path. Grants are
// combinational. SRAM strobes, address and data come from registers, and read
// data is returned per port with a one-cycle valid pulse.

// Per-port read-return register: captures SRAM Q when this port's read completes
module sram_arb_rport #(
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          BGN,
  input  logic          done,
  input  logic [DW-1:0] q,
  output logic [DW-1:0] rq,
  output logic          rv
);
  // Data is held until this port's next read lands; writes never touch it
  always_ff @(posedge CLK or negedge BGN) begin
    if (!BGN) begin
      rq <= '0;
      rv <= 1'b0;
    end else begin
      rv <= done;
      if (done) rq <= q;
    end
  end
endmodule

module sram_access_arbiter #(
  parameter int MEMORY_DATA_WIDTH = 8,
  parameter int MEMORY_ADDR_WIDTH = 9,
  parameter int RD_LATENCY        = 1,
  parameter int PRIO_MODE         = 0
) (
  input  logic                         CLK,
  input  logic                         BGN,
  input  logic                         R0_REQ,
  input  logic                         R0_WE,
  input  logic [MEMORY_ADDR_WIDTH-1:0] R0_A,
  input  logic [MEMORY_DATA_WIDTH-1:0] R0_D,
  output logic                         R0_GNT,
  output logic [MEMORY_DATA_WIDTH-1:0] R0_Q,
  output logic                         R0_VLD,
  input  logic                         R1_REQ,
  input  logic                         R1_WE,
  input  logic [MEMORY_ADDR_WIDTH-1:0] R1_A,
  input  logic [MEMORY_DATA_WIDTH-1:0] R1_D,
  output logic                         R1_GNT,
  output logic [MEMORY_DATA_WIDTH-1:0] R1_Q,
  output logic                         R1_VLD,
  output logic                         CEN,
  output logic                         WEN,
  output logic [MEMORY_ADDR_WIDTH-1:0] A,
  output logic [MEMORY_DATA_WIDTH-1:0] D,
  input  logic [MEMORY_DATA_WIDTH-1:0] Q,
  output logic                         BUSY
);
  localparam int NUM_PORTS = 2;
  localparam int AW = MEMORY_ADDR_WIDTH;
  localparam int DW = MEMORY_DATA_WIDTH;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ACC, WAIT} state_t;

  state_t                           state, state_nxt;
  cmd_t   [NUM_PORTS-1:0]           cmd;
  logic   [NUM_PORTS-1:0]           req, gnt, rdone, rvld;
  logic   [NUM_PORTS-1:0][DW-1:0]   rdata;
  logic                             op_we, owner, last_gnt, win, gsel, wlast;
  logic   [1:0]                     wcnt;

  assign req    = {R1_REQ, R0_REQ};
  assign cmd[0] = '{we: R0_WE, a: R0_A, d: R0_D};
  assign cmd[1] = '{we: R1_WE, a: R1_A, d: R1_D};
  assign R0_GNT = gnt[0];
  assign R1_GNT = gnt[1];
  assign R0_Q   = rdata[0];
  assign R1_Q   = rdata[1];
  assign R0_VLD = rvld[0];
  assign R1_VLD = rvld[1];
  assign BUSY   = (state != IDLE);
  assign wlast  = (state == WAIT) && (wcnt == 2'd1);
  assign gsel   = gnt[1];

  // State register
  always_ff @(posedge CLK or negedge BGN) begin
    if (!BGN) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state: any grant starts a command cycle; reads drain through WAIT
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|gnt) state_nxt = ACC;
      ACC:     if (|gnt)      state_nxt = ACC;
               else if (op_we) state_nxt = IDLE;
               else            state_nxt = WAIT;
      WAIT:    if (wlast) state_nxt = (|gnt) ? ACC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Accept window and arbitration: closed while a read owns the SRAM,
  // reopening on the last latency cycle so reads can run back to back
  always_comb begin
    win = (state == IDLE) || ((state == ACC) && op_we) || wlast;
    gnt = '0;
    if (win) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = ((PRIO_MODE == 1) || last_gnt) ? 2'b01 : 2'b10;
        default: gnt = '0;
      endcase
    end
  end

  // SRAM command registers; address and data forced to zero when deselected
  always_ff @(posedge CLK or negedge BGN) begin
    if (!BGN) begin
      CEN      <= 1'b1;
      WEN      <= 1'b1;
      A        <= '0;
      D        <= '0;
      op_we    <= 1'b0;
      owner    <= 1'b0;
      last_gnt <= 1'b1;
    end else if (|gnt) begin
      CEN      <= 1'b0;
      WEN      <= ~cmd[gsel].we;
      A        <= cmd[gsel].a;
      D        <= cmd[gsel].we ? cmd[gsel].d : '0;
      op_we    <= cmd[gsel].we;
      owner    <= gsel;
      last_gnt <= gsel;
    end else begin
      CEN <= 1'b1;
      WEN <= 1'b1;
      A   <= '0;
      D   <= '0;
    end
  end

  // Read latency counter: loaded when a read leaves ACC, counts down in WAIT
  always_ff @(posedge CLK or negedge BGN) begin
    if (!BGN)                          wcnt <= '0;
    else if ((state == ACC) && !op_we) wcnt <= 2'(RD_LATENCY);
    else if (state == WAIT)            wcnt <= wcnt - 2'd1;
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign rdone[p] = wlast && (owner == 1'(p));
    sram_arb_rport #(.DW(DW)) u_rport (
      .CLK  (CLK),
      .BGN  (BGN),
      .done (rdone[p]),
      .q    (Q),
      .rq   (rdata[p]),
      .rv   (rvld[p])
    );
  end
endmodule

// File: tb/tb_sram_access_arbiter.sv
// Bench for sram_access_arbiter: two instances (round-robin RD_LATENCY=1 and
// fixed-priority RD_LATENCY=2), each with a behavioural SRAM. Directed
// scenarios plus a randomized run against a timestamp-based reference model.
module tb_sram_access_arbiter;
  localparam int AW = 9;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic bgn = 1'b0;
  logic mem_clr = 1'b1;
  always #5 clk = ~clk;

  logic          req [2][2];
  logic          we  [2][2];
  logic [AW-1:0] adr [2][2];
  logic [DW-1:0] wd  [2][2];
  wire           gnt [2][2];
  wire           vld [2][2];
  wire  [DW-1:0] rq  [2][2];
  wire           cen [2];
  wire           wen [2];
  wire  [AW-1:0] sa  [2];
  wire  [DW-1:0] sd  [2];
  wire  [DW-1:0] q   [2];
  wire           busy[2];

  int errors = 0;
  int checks = 0;

  sram_access_arbiter #(.MEMORY_DATA_WIDTH(DW), .MEMORY_ADDR_WIDTH(AW), .RD_LATENCY(1), .PRIO_MODE(0)) dut_rr (
    .CLK(clk), .BGN(bgn),
    .R0_REQ(req[0][0]), .R0_WE(we[0][0]), .R0_A(adr[0][0]), .R0_D(wd[0][0]),
    .R0_GNT(gnt[0][0]), .R0_Q(rq[0][0]), .R0_VLD(vld[0][0]),
    .R1_REQ(req[0][1]), .R1_WE(we[0][1]), .R1_A(adr[0][1]), .R1_D(wd[0][1]),
    .R1_GNT(gnt[0][1]), .R1_Q(rq[0][1]), .R1_VLD(vld[0][1]),
    .CEN(cen[0]), .WEN(wen[0]), .A(sa[0]), .D(sd[0]), .Q(q[0]), .BUSY(busy[0]));

  sram_access_arbiter #(.MEMORY_DATA_WIDTH(DW), .MEMORY_ADDR_WIDTH(AW), .RD_LATENCY(2), .PRIO_MODE(1)) dut_fp (
    .CLK(clk), .BGN(bgn),
    .R0_REQ(req[1][0]), .R0_WE(we[1][0]), .R0_A(adr[1][0]), .R0_D(wd[1][0]),
    .R0_GNT(gnt[1][0]), .R0_Q(rq[1][0]), .R0_VLD(vld[1][0]),
    .R1_REQ(req[1][1]), .R1_WE(we[1][1]), .R1_A(adr[1][1]), .R1_D(wd[1][1]),
    .R1_GNT(gnt[1][1]), .R1_Q(rq[1][1]), .R1_VLD(vld[1][1]),
    .CEN(cen[1]), .WEN(wen[1]), .A(sa[1]), .D(sd[1]), .Q(q[1]), .BUSY(busy[1]));

  // Behavioural SRAM: Q valid RD_LATENCY edges after the command edge
  for (genvar k = 0; k < 2; k++) begin : g_sram
    logic [DW-1:0] mem  [512];
    logic [DW-1:0] pipe [3];
    always @(posedge clk) begin
      if (mem_clr) begin
        for (int i = 0; i < 512; i++) mem[i] <= '0;
      end else if (!cen[k]) begin
        if (!wen[k]) mem[sa[k]] <= sd[k];
        else         pipe[0] <= mem[sa[k]];
      end
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign q[k] = pipe[k];
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic drv(input int k, input int p, input logic r, input logic w,
                     input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[k][p] = r; we[k][p] = w; adr[k][p] = a; wd[k][p] = d;
  endtask

  task automatic idle_all();
    for (int k = 0; k < 2; k++)
      for (int p = 0; p < 2; p++) drv(k, p, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      checks++; if ({cen[k], wen[k]} !== 2'b11) begin errors++; $display("FAIL rst_strobes inst%0d got=%b exp=11", k, {cen[k], wen[k]}); end
      checks++; if ({sa[k], sd[k]} !== '0) begin errors++; $display("FAIL rst_ad inst%0d got=%h/%h exp=0/0", k, sa[k], sd[k]); end
      checks++; if (busy[k] !== 1'b0) begin errors++; $display("FAIL rst_busy inst%0d got=%b exp=0", k, busy[k]); end
      checks++; if ({vld[k][1], vld[k][0]} !== 2'b00) begin errors++; $display("FAIL rst_vld inst%0d got=%b exp=00", k, {vld[k][1], vld[k][0]}); end
      checks++; if ({rq[k][1], rq[k][0]} !== 16'h0) begin errors++; $display("FAIL rst_q inst%0d got=%h exp=0", k, {rq[k][1], rq[k][0]}); end
    end
  endtask

  task automatic test_single_write();
    drv(0, 0, 1'b1, 1'b1, 9'h1A5, 8'h3C);
    smp();
    checks++; if ({gnt[0][1], gnt[0][0]} !== 2'b01) begin errors++; $display("FAIL wr_gnt got=%b exp=01", {gnt[0][1], gnt[0][0]}); end
    cyc(); drv(0, 0, 1'b0, 1'b0, '0, '0);
    smp();
    checks++; if ({cen[0], wen[0], busy[0]} !== 3'b001) begin errors++; $display("FAIL wr_cmd_strobes got=%b exp=001", {cen[0], wen[0], busy[0]}); end
    checks++; if ({sa[0], sd[0]} !== {9'h1A5, 8'h3C}) begin errors++; $display("FAIL wr_cmd_ad got=%h/%h exp=1a5/3c", sa[0], sd[0]); end
    cyc(); smp();
    checks++; if ({cen[0], busy[0], sa[0], sd[0]} !== {1'b1, 1'b0, 17'h0}) begin errors++; $display("FAIL wr_after got cen=%b busy=%b a=%h d=%h exp 1 0 0 0", cen[0], busy[0], sa[0], sd[0]); end
    cyc();
  endtask

  task automatic test_readback();
    drv(0, 1, 1'b1, 1'b0, 9'h1A5, 8'h00);
    smp();
    checks++; if ({gnt[0][1], gnt[0][0]} !== 2'b10) begin errors++; $display("FAIL rd_gnt got=%b exp=10", {gnt[0][1], gnt[0][0]}); end
    cyc(); drv(0, 1, 1'b0, 1'b0, '0, '0);
    smp();
    checks++; if ({cen[0], wen[0], sa[0], sd[0]} !== {2'b01, 9'h1A5, 8'h00}) begin errors++; $display("FAIL rd_cmd got cen=%b wen=%b a=%h d=%h exp 0 1 1a5 0", cen[0], wen[0], sa[0], sd[0]); end
    cyc(); smp();
    checks++; if ({cen[0], vld[0][1]} !== 2'b10) begin errors++; $display("FAIL rd_wait got cen=%b vld=%b exp 1 0", cen[0], vld[0][1]); end
    cyc(); smp();
    checks++; if ({vld[0][1], vld[0][0], rq[0][1]} !== {2'b10, 8'h3C}) begin errors++; $display("FAIL rd_vld got vld=%b%b q=%h exp 10 3c", vld[0][1], vld[0][0], rq[0][1]); end
    cyc(); smp();
    checks++; if ({vld[0][1], rq[0][1]} !== {1'b0, 8'h3C}) begin errors++; $display("FAIL rd_hold got vld=%b q=%h exp 0 3c", vld[0][1], rq[0][1]); end
    cyc();
  endtask

  task automatic test_contention_rr();
    bgn = 1'b0; #2; bgn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drv(0, 0, 1'b1, 1'b1, 9'(9'h100 + i), 8'(i));
      drv(0, 1, 1'b1, 1'b1, 9'(9'h140 + i), 8'(8'h80 + i));
      smp();
      checks++;
      if ({gnt[0][1], gnt[0][0]} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL rr_gnt step%0d got=%b exp=%b", i, {gnt[0][1], gnt[0][0]}, (i % 2 == 0) ? 2'b01 : 2'b10);
      end
      cyc();
    end
    idle_all(); repeat (3) cyc();
  endtask

  task automatic test_contention_fp();
    for (int i = 0; i < 5; i++) begin
      drv(1, 0, i < 4, 1'b1, 9'(9'h180 + i), 8'(i));
      drv(1, 1, 1'b1, 1'b1, 9'h1C0, 8'h77);
      smp();
      checks++;
      if ({gnt[1][1], gnt[1][0]} !== ((i < 4) ? 2'b01 : 2'b10)) begin
        errors++; $display("FAIL fp_gnt step%0d got=%b exp=%b", i, {gnt[1][1], gnt[1][0]}, (i < 4) ? 2'b01 : 2'b10);
      end
      cyc();
    end
    idle_all(); repeat (3) cyc();
  endtask

  task automatic test_throughput();
    int gc[2], vc[2], idx, nv;
    logic [DW-1:0] vd[2];
    for (int i = 0; i < 6; i++) begin
      drv(1, 0, i < 4, 1'b1, 9'(i), 8'(8'h10 + i));
      smp();
      if (i < 4) begin
        checks++; if (gnt[1][0] !== 1'b1) begin errors++; $display("FAIL tp_wgnt step%0d got=%b exp=1", i, gnt[1][0]); end
      end
      if (i >= 1 && i <= 4) begin
        checks++;
        if ({cen[1], sa[1], sd[1]} !== {1'b0, 9'(i - 1), 8'(8'h10 + i - 1)}) begin
          errors++; $display("FAIL tp_wcmd step%0d got cen=%b a=%h d=%h exp 0 %h %h", i, cen[1], sa[1], sd[1], i - 1, 8'h10 + i - 1);
        end
      end
      if (i == 5) begin
        checks++; if (cen[1] !== 1'b1) begin errors++; $display("FAIL tp_wend got cen=%b exp=1", cen[1]); end
      end
      cyc();
    end
    idle_all(); cyc();
    idx = 0; nv = 0; gc = '{-1, -1}; vc = '{-1, -1}; vd = '{8'h0, 8'h0};
    for (int c = 0; c < 12; c++) begin
      drv(1, 0, idx < 2, 1'b0, 9'(idx), 8'h00);
      smp();
      if (gnt[1][0] && idx < 2) begin gc[idx] = c; idx++; end
      if (vld[1][0]) begin
        if (nv < 2) begin vc[nv] = c; vd[nv] = rq[1][0]; end
        nv++;
      end
      cyc();
    end
    idle_all();
    checks++; if ({idx, nv} !== {32'd2, 32'd2}) begin errors++; $display("FAIL tp_counts got gnts=%0d vlds=%0d exp 2 2", idx, nv); end
    checks++; if ({gc[0], gc[1]} !== {32'd0, 32'd3}) begin errors++; $display("FAIL tp_rgnt_spacing got %0d,%0d exp 0,3", gc[0], gc[1]); end
    checks++; if ({vc[0], vc[1]} !== {32'd4, 32'd7}) begin errors++; $display("FAIL tp_vld_time got %0d,%0d exp 4,7", vc[0], vc[1]); end
    checks++; if ({vd[0], vd[1]} !== 16'h1011) begin errors++; $display("FAIL tp_vld_data got %h,%h exp 10,11", vd[0], vd[1]); end
    repeat (3) cyc();
  endtask

  task automatic test_overlap();
    int first0 = -1;
    for (int c = 0; c < 7; c++) begin
      drv(1, 1, c == 0, 1'b0, 9'h002, 8'h00);
      drv(1, 0, c >= 1 && first0 < 0, 1'b1, 9'h0F0, 8'h5A);
      smp();
      if (gnt[1][0] && first0 < 0) first0 = c;
      if (c == 4) begin
        checks++;
        if ({cen[1], wen[1], sa[1], sd[1]} !== {2'b00, 9'h0F0, 8'h5A}) begin
          errors++; $display("FAIL ov_cmd got cen=%b wen=%b a=%h d=%h exp 0 0 0f0 5a", cen[1], wen[1], sa[1], sd[1]);
        end
        checks++;
        if ({vld[1][1], rq[1][1]} !== {1'b1, 8'h12}) begin
          errors++; $display("FAIL ov_vld got vld=%b q=%h exp 1 12", vld[1][1], rq[1][1]);
        end
      end
      cyc();
    end
    idle_all();
    checks++; if (first0 !== 3) begin errors++; $display("FAIL ov_gnt_cycle got=%0d exp=3", first0); end
    repeat (3) cyc();
  endtask

  task automatic test_reset_midwait();
    logic seen = 1'b0;
    int gcyc = -1, vcyc = -1;
    logic [DW-1:0] vq = '0;
    drv(1, 1, 1'b1, 1'b0, 9'h0F0, 8'h00);
    smp();
    checks++; if (gnt[1][1] !== 1'b1) begin errors++; $display("FAIL rmw_gnt got=%b exp=1", gnt[1][1]); end
    cyc(); drv(1, 1, 1'b0, 1'b0, '0, '0);
    cyc();
    bgn = 1'b0; #1;
    checks++;
    if ({cen[1], wen[1], busy[1], sa[1], sd[1]} !== {3'b110, 17'h0}) begin
      errors++; $display("FAIL rmw_rst got cen=%b wen=%b busy=%b a=%h d=%h exp 1 1 0 0 0", cen[1], wen[1], busy[1], sa[1], sd[1]);
    end
    checks++; if ({vld[1][1], rq[1][1]} !== 9'h0) begin errors++; $display("FAIL rmw_rst_q got vld=%b q=%h exp 0 0", vld[1][1], rq[1][1]); end
    for (int c = 0; c < 6; c++) begin
      if (c == 2) bgn = 1'b1;
      smp();
      if (vld[1][1]) seen = 1'b1;
      cyc();
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rmw_no_vld got=%b exp=0", seen); end
    for (int c = 0; c < 10; c++) begin
      drv(1, 1, gcyc < 0, 1'b0, 9'h0F0, 8'h00);
      smp();
      if (gnt[1][1] && gcyc < 0) gcyc = c;
      if (vld[1][1] && vcyc < 0) begin vcyc = c; vq = rq[1][1]; end
      cyc();
    end
    idle_all();
    checks++; if ({gcyc, vcyc} !== {32'd0, 32'd4}) begin errors++; $display("FAIL rmw_reread_time got gnt=%0d vld=%0d exp 0 4", gcyc, vcyc); end
    checks++; if (vq !== 8'h5A) begin errors++; $display("FAIL rmw_reread_data got=%h exp=5a", vq); end
    repeat (3) cyc();
  endtask

  typedef struct {int cyc; int p; logic [DW-1:0] d;} rd_t;

  task automatic test_random(input int k);
    logic [DW-1:0] mm [512];
    rd_t vq[$];
    logic pend[2], pw[2];
    logic [AW-1:0] pa[2];
    logic [DW-1:0] pd[2], erq[2];
    logic ecen, ewen;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [1:0] ev;
    int rl, g, last, next_free, busy_last;
    rl = (k == 0) ? 1 : 2;
    for (int i = 0; i < 512; i++) mm[i] = '0;
    pend = '{1'b0, 1'b0}; pw = '{1'b0, 1'b0}; pa = '{9'h0, 9'h0}; pd = '{8'h0, 8'h0};
    erq = '{8'h0, 8'h0};
    ecen = 1'b1; ewen = 1'b1; ea = '0; ed = '0;
    last = 1; next_free = 0; busy_last = -1;
    idle_all();
    bgn = 1'b0; mem_clr = 1'b1;
    cyc(); cyc();
    bgn = 1'b1; mem_clr = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p] = 1'b1; pw[p] = 1'($urandom_range(0, 1));
          pa[p] = 9'($urandom_range(0, 15)); pd[p] = 8'($urandom);
        end else if (pend[p] && $urandom_range(0, 15) == 0) begin
          pend[p] = 1'b0;
        end
        drv(k, p, pend[p], pw[p], pa[p], pd[p]);
      end
      smp();
      g = -1;
      if (c >= next_free) begin
        if (pend[0] && pend[1]) g = (k == 1 || last == 1) ? 0 : 1;
        else if (pend[0])       g = 0;
        else if (pend[1])       g = 1;
      end
      ev = 2'b00;
      while (vq.size() > 0 && vq[0].cyc == c) begin
        ev[vq[0].p] = 1'b1; erq[vq[0].p] = vq[0].d; void'(vq.pop_front());
      end
      checks++;
      if ({gnt[k][1], gnt[k][0]} !== {g == 1, g == 0}) begin
        errors++; $display("FAIL rnd_gnt inst%0d cyc%0d got=%b exp=%b", k, c, {gnt[k][1], gnt[k][0]}, {g == 1, g == 0});
      end
      checks++;
      if ({cen[k], wen[k], sa[k], sd[k]} !== {ecen, ewen, ea, ed}) begin
        errors++; $display("FAIL rnd_sram inst%0d cyc%0d got %b%b %h %h exp %b%b %h %h", k, c, cen[k], wen[k], sa[k], sd[k], ecen, ewen, ea, ed);
      end
      checks++;
      if (busy[k] !== (c <= busy_last)) begin
        errors++; $display("FAIL rnd_busy inst%0d cyc%0d got=%b exp=%b", k, c, busy[k], c <= busy_last);
      end
      checks++;
      if ({vld[k][1], vld[k][0], rq[k][1], rq[k][0]} !== {ev, erq[1], erq[0]}) begin
        errors++; $display("FAIL rnd_rdata inst%0d cyc%0d got vld=%b%b q=%h,%h exp vld=%b q=%h,%h", k, c, vld[k][1], vld[k][0], rq[k][1], rq[k][0], ev, erq[1], erq[0]);
      end
      if (g >= 0) begin
        ecen = 1'b0; ewen = !pw[g]; ea = pa[g]; ed = pw[g] ? pd[g] : '0;
        last = g;
        if (pw[g]) begin
          mm[pa[g]] = pd[g]; next_free = c + 1; busy_last = c + 1;
        end else begin
          vq.push_back('{c + 2 + rl, g, mm[pa[g]]});
          next_free = c + 1 + rl; busy_last = c + 1 + rl;
        end
        pend[g] = 1'b0;
      end else begin
        ecen = 1'b1; ewen = 1'b1; ea = '0; ed = '0;
      end
      cyc();
    end
    idle_all(); repeat (4) cyc();
  endtask

  initial begin
    idle_all();
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    bgn = 1'b1; mem_clr = 1'b0;
    cyc();
    test_single_write();
    test_readback();
    test_contention_rr();
    test_contention_fp();
    test_throughput();
    test_overlap();
    test_reset_midwait();
    test_random(0);
    test_random(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
